led_colour_driver: RTL and testbench
====================================

Name: led_colour_driver

Overview:
- Consumer end of the 3-bit colour code produced by the lighting controller.
- Decodes colour[2:0] into per-channel RGB target intensities.
- Fades each channel linearly toward its target and drives three PWM outputs to the physical RGB LED.
- Sits between the lighting controller and the board LED pins, in the same clock domain.

Parameters:
- PWM_BITS, 8, width of the PWM counter and of each channel level.
- STEP_CYCLES, 4, clock cycles per fade step; legal range ≥1.
- MAX_LEVEL, 255, level used for an "on" channel; must be ≤ 2^PWM_BITS-1.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- colour  input  3  colour code from the lighting controller: bit2=red, bit1=green, bit0=blue.
- pwm_r  output  1  red LED drive, registered.
- pwm_g  output  1  green LED drive, registered.
- pwm_b  output  1  blue LED drive, registered.
- level_r/level_g/level_b  output  PWM_BITS each  current channel intensity, for debug.
- busy  output  1  high while any level differs from its target.

Behaviour:
- Reset (rst=0, asynchronous assert; deassertion takes effect at the next clk edge):
  - colour_q=000, all levels=0, pwm_cnt=0, step_cnt=0.
  - pwm_r/g/b=0, busy=0.
- Input capture:
  - colour_q<=colour on every clk edge; no handshake.
  - Per channel, target = (colour_q bit set) ? MAX_LEVEL : 0.
  - Code 000 means all off; 111 means white. All 8 codes are legal.
- Fade prescaler:
  - step_cnt counts 0..STEP_CYCLES-1 and wraps.
  - tick=1 in the cycle where step_cnt==STEP_CYCLES-1.
  - With STEP_CYCLES=1, tick is high every cycle.
- Fade update, on tick, independently per channel:
  - level<target: level+1.
  - level>target: level-1.
  - equal: hold.
  - Levels never exceed MAX_LEVEL and never underflow below 0.
- Target change mid-fade:
  - The new target applies from the cycle after colour_q updates.
  - The fade reverses or continues from the current level; no jump, no restart of step_cnt.
- busy = registered OR of (level!=target) across the three channels, evaluated after the level update.
  - busy drops the cycle after the final step lands.
- PWM:
  - pwm_cnt is a free-running PWM_BITS-bit counter that wraps 2^PWM_BITS-1 -> 0.
  - pwm_x <= (pwm_cnt < level_x), registered.
  - Duty = level/2^PWM_BITS; level 0 gives constant low.
  - level 255 (PWM_BITS=8) gives high for 255 of every 256 cycles.
- PWM is glitch-free by construction: outputs come straight from flops.
- Level changes are not synchronised to the PWM period. A single period may mix old and new level; this is accepted.
- Latency from a colour input change to the first level step: 1 cycle (capture) plus up to STEP_CYCLES cycles (to next tick).
- Full fade 0->MAX_LEVEL takes MAX_LEVEL ticks = MAX_LEVEL*STEP_CYCLES cycles.
- Reset mid-fade: all levels return to 0 immediately (async). Outputs low, busy=0.
- Colour held constant (button released upstream): levels converge, then hold; busy=0 and PWM duty is stable.

Test Plan:
- Reset and idle:
  - Apply rst=0 with colour=101, then release.
  - Required: at release all outputs 0, busy=0.
  - One cycle later colour_q=101 and busy rises.
- Fade up (PWM_BITS=8, STEP_CYCLES=4, MAX_LEVEL=255):
  - colour 000 -> 001.
  - Required: level_b increments every 4 cycles and reaches 255 after 1020 cycles (±4). busy falls the cycle after.
  - level_r and level_g stay 0 throughout.
- Mid-fade reversal:
  - colour=010 until level_g=100, then colour=000.
  - Required: level_g steps 100->99->...->0 with no jump; busy=0 after ~400 more cycles.
- Channel swap:
  - From settled colour=100, switch to 001.
  - Required: level_r falls and level_b rises simultaneously, one step per tick. They cross at 127/128. busy=1 throughout the swap.
- PWM duty:
  - Force settle at level_r=64 (colour held, MAX_LEVEL=64).
  - Required: pwm_r high exactly 64 of every 256 cycles.
  - level 0 gives pwm_r never high; level 255 gives exactly one low cycle per 256.
- Async reset mid-fade:
  - Assert rst=0 between clock edges while level_g=50.
  - Required: level_g=0 and pwm_g=0 without waiting for an edge.
  - After release, the fade restarts from 0.

Source files
------------

// File: rtl/led_colour_driver.sv
// led_colour_driver: decodes a 3-bit colour code into RGB targets, fades each
// channel linearly toward its target and drives registered PWM outputs.
module led_colour_driver #(
  parameter int PWM_BITS    = 8,
  parameter int STEP_CYCLES = 4,
  parameter int MAX_LEVEL   = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2:0]          colour,
  output logic                pwm_r,
  output logic                pwm_g,
  output logic                pwm_b,
  output logic [PWM_BITS-1:0] level_r,
  output logic [PWM_BITS-1:0] level_g,
  output logic [PWM_BITS-1:0] level_b,
  output logic                busy
);
  localparam int SW = STEP_CYCLES > 1 ? $clog2(STEP_CYCLES) : 1;
  logic [2:0]                   colour_q;
  logic [SW-1:0]                step_cnt;
  logic [PWM_BITS-1:0]          pwm_cnt;
  logic [2:0][PWM_BITS-1:0]     level, level_nxt, target;
  logic [2:0]                   pwm;
  logic                         tick;
  assign tick = step_cnt == SW'(STEP_CYCLES - 1);
  // index 2/1/0 = red/green/blue, matching the colour code bit order
  for (genvar i = 0; i < 3; i++) begin : g_ch
    assign target[i]    = colour_q[i] ? PWM_BITS'(MAX_LEVEL) : '0;
    assign level_nxt[i] = !tick                 ? level[i] :
                          level[i] < target[i]  ? level[i] + 1'b1 :
                          level[i] > target[i]  ? level[i] - 1'b1 : level[i];
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      colour_q <= '0;
      step_cnt <= '0;
      pwm_cnt  <= '0;
      level    <= '0;
      pwm      <= '0;
      busy     <= 1'b0;
    end else begin
      colour_q <= colour;
      step_cnt <= tick ? '0 : step_cnt + 1'b1;
      pwm_cnt  <= pwm_cnt + 1'b1;
      level    <= level_nxt;
      busy     <= level != target;
      pwm      <= {pwm_cnt < level[2], pwm_cnt < level[1], pwm_cnt < level[0]};
    end
  assign {pwm_r, pwm_g, pwm_b}       = pwm;
  assign {level_r, level_g, level_b} = level;
endmodule

// File: tb/tb_led_colour_driver.sv
// tb_led_colour_driver: directed scoreboard bench; stimulus queues expected
// values per cycle, monitors pop and compare them at negedge or reset fall.
module tb_led_colour_driver;
  typedef struct {
    int    cyc;
    int    start;
    int    sel;
    int    val;
    string name;
  } item_t;
  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] colour, colour64;
  logic       pwm_r, pwm_g, pwm_b, busy;
  logic [7:0] level_r, level_g, level_b;
  logic       pwm_r64, pwm_g64, pwm_b64, busy64;
  logic [7:0] level_r64, level_g64, level_b64;
  int         cyc = 0;
  int         base = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  item_t      q[$];
  item_t      rq[$];
  item_t      mit, rit;
  int         cum[4][16384];

  led_colour_driver dut (
    .clk(clk), .rst(rst), .colour(colour),
    .pwm_r(pwm_r), .pwm_g(pwm_g), .pwm_b(pwm_b),
    .level_r(level_r), .level_g(level_g), .level_b(level_b), .busy(busy)
  );

  led_colour_driver #(.PWM_BITS(8), .STEP_CYCLES(1), .MAX_LEVEL(64)) u64 (
    .clk(clk), .rst(rst), .colour(colour64),
    .pwm_r(pwm_r64), .pwm_g(pwm_g64), .pwm_b(pwm_b64),
    .level_r(level_r64), .level_g(level_g64), .level_b(level_b64), .busy(busy64)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] probe(int sel);
    case (sel)
      0:       return 32'(level_r);
      1:       return 32'(level_g);
      2:       return 32'(level_b);
      3:       return 32'(busy);
      4:       return 32'(pwm_r);
      5:       return 32'(pwm_g);
      6:       return 32'(pwm_b);
      11:      return 32'(level_r64);
      12:      return 32'(busy64);
      default: return 'x;
    endcase
  endfunction

  function automatic void check(item_t it, logic [31:0] act);
    n_checks++;
    if (act !== it.val) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", it.name, act, it.val, cyc);
    end
  endfunction

  // sel 7..10 are duty counts over (start, cyc] for pwm_r/g/b and u64 pwm_r
  task automatic push(int n, int sel, int val, string name, int n0 = 0);
    item_t it;
    int    i = 0;
    it.cyc = base + n; it.start = base + n0; it.sel = sel; it.val = val; it.name = name;
    while (i < q.size() && q[i].cyc <= it.cyc) i++;
    q.insert(i, it);
  endtask

  task automatic rpush(int sel, int val, string name);
    item_t it;
    it.cyc = 0; it.start = 0; it.sel = sel; it.val = val; it.name = name;
    rq.push_back(it);
  endtask

  task automatic wait_to(int n);
    while (cyc < base + n) @(negedge clk);
  endtask

  // called at a negedge: async assert mid-cycle, release at the next negedge
  task automatic restart(logic [2:0] c);
    #2 rst = 1'b0;
    colour = c;
    @(negedge clk);
    rst  = 1'b1;
    base = cyc;
  endtask

  always @(negedge clk) begin
    cum[0][cyc] = (cyc > 0 ? cum[0][cyc-1] : 0) + int'(pwm_r);
    cum[1][cyc] = (cyc > 0 ? cum[1][cyc-1] : 0) + int'(pwm_g);
    cum[2][cyc] = (cyc > 0 ? cum[2][cyc-1] : 0) + int'(pwm_b);
    cum[3][cyc] = (cyc > 0 ? cum[3][cyc-1] : 0) + int'(pwm_r64);
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      mit = q.pop_front();
      if (mit.cyc < cyc) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s: not sampled at cycle %0d, expected %0d", mit.name, mit.cyc, mit.val);
      end else if (mit.sel >= 7 && mit.sel <= 10)
        check(mit, 32'(cum[mit.sel-7][cyc] - cum[mit.sel-7][mit.start]));
      else
        check(mit, probe(mit.sel));
    end
  end

  always @(negedge rst) begin
    #1;
    while (rq.size() > 0) begin
      rit = rq.pop_front();
      check(rit, probe(rit.sel));
    end
  end

  initial begin
    rst = 1'b0;
    colour = 3'b101;
    colour64 = 3'b100;
    // reset and idle
    @(negedge clk);
    base = cyc;
    push(1, 0, 0, "rst_level_r"); push(1, 1, 0, "rst_level_g"); push(1, 2, 0, "rst_level_b");
    push(1, 3, 0, "rst_busy");    push(1, 4, 0, "rst_pwm_r");   push(1, 5, 0, "rst_pwm_g");
    push(1, 6, 0, "rst_pwm_b");   push(1, 11, 0, "rst_level_r64");
    @(negedge clk);
    rst = 1'b1;
    base = cyc;
    push(1, 3, 0, "busy_at_release"); push(2, 3, 1, "busy_rises");
    push(3, 0, 0, "lr_before_tick");  push(4, 0, 1, "lr_first_tick");
    push(4, 2, 1, "lb_first_tick");   push(4, 1, 0, "lg_stays_0");
    push(20, 0, 5, "lr_n20");
    wait_to(20);
    rpush(0, 0, "async_lr"); rpush(2, 0, "async_lb"); rpush(3, 0, "async_busy");
    // fade up on blue, plus the MAX_LEVEL=64 / STEP_CYCLES=1 instance
    restart(3'b001);
    push(4, 2, 1, "up_lb_4");      push(7, 2, 1, "up_lb_7");       push(8, 2, 2, "up_lb_8");
    push(403, 2, 100, "up_lb_403"); push(1019, 2, 254, "up_lb_1019");
    push(1020, 2, 255, "up_lb_1020"); push(1020, 3, 1, "up_busy_1020");
    push(1021, 3, 0, "up_busy_1021"); push(1021, 0, 0, "up_lr_0"); push(1021, 1, 0, "up_lg_0");
    push(1200, 2, 255, "up_lb_hold");
    push(1356, 9, 255, "duty_b_255", 1100);
    push(1356, 8, 0, "duty_g_0", 1100);
    push(1356, 10, 64, "duty_r64_64", 1100);
    push(1, 11, 0, "l64_n1");   push(2, 11, 1, "l64_n2");   push(10, 11, 9, "l64_n10");
    push(65, 11, 64, "l64_n65"); push(65, 12, 1, "b64_n65"); push(66, 11, 64, "l64_n66");
    push(66, 12, 0, "b64_n66");  push(1100, 11, 64, "l64_hold");
    wait_to(1360);
    rpush(2, 0, "async_lb_255"); rpush(11, 0, "async_l64");
    // mid-fade reversal on green
    restart(3'b010);
    push(400, 1, 100, "rev_lg_400"); push(403, 1, 100, "rev_lg_403"); push(404, 1, 99, "rev_lg_404");
    push(408, 1, 98, "rev_lg_408");  push(600, 0, 0, "rev_lr_0");    push(700, 1, 25, "rev_lg_700");
    push(799, 1, 1, "rev_lg_799");   push(800, 1, 0, "rev_lg_800");   push(800, 3, 1, "rev_busy_800");
    push(801, 3, 0, "rev_busy_801"); push(900, 1, 0, "rev_lg_hold");
    wait_to(400);
    colour = 3'b000;
    wait_to(905);
    // channel swap red -> blue
    restart(3'b100);
    push(1020, 0, 255, "sw_lr_settle"); push(1024, 3, 0, "sw_busy_idle");
    push(1025, 3, 0, "sw_busy_1025");   push(1026, 3, 1, "sw_busy_1026");
    push(1028, 0, 254, "sw_lr_1028");   push(1028, 2, 1, "sw_lb_1028");
    push(1532, 0, 128, "sw_lr_1532");   push(1532, 2, 127, "sw_lb_1532"); push(1532, 3, 1, "sw_busy_1532");
    push(1536, 0, 127, "sw_lr_1536");   push(1536, 2, 128, "sw_lb_1536"); push(1800, 3, 1, "sw_busy_1800");
    push(2043, 0, 1, "sw_lr_2043");     push(2043, 2, 254, "sw_lb_2043");
    push(2044, 0, 0, "sw_lr_2044");     push(2044, 2, 255, "sw_lb_2044"); push(2044, 3, 1, "sw_busy_2044");
    push(2045, 3, 0, "sw_busy_2045");
    wait_to(1024);
    colour = 3'b001;
    wait_to(2050);
    rpush(2, 0, "async_lb_swap");
    // async reset mid-fade on green, then fade restarts from zero
    restart(3'b010);
    push(200, 1, 50, "ar_lg_200"); push(201, 1, 50, "ar_lg_201"); push(201, 3, 1, "ar_busy_201");
    wait_to(201);
    rpush(1, 0, "ar_lg_async"); rpush(5, 0, "ar_pwm_g_async"); rpush(3, 0, "ar_busy_async");
    restart(3'b010);
    push(3, 1, 0, "ar2_lg_3"); push(4, 1, 1, "ar2_lg_4"); push(8, 1, 2, "ar2_lg_8");
    push(40, 1, 10, "ar2_lg_40"); push(41, 3, 1, "ar2_busy_41");
    wait_to(45);
    for (int i = 0; i < 100 && q.size() > 0; i++) @(negedge clk);
    while (q.size() > 0) begin
      mit = q.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL %s: never sampled, expected %0d", mit.name, mit.val);
    end
    while (rq.size() > 0) begin
      rit = rq.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL %s: never sampled, expected %0d", rit.name, rit.val);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
